// File: rtl/contador_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
// Shared definitions for the contador family of counters.
//   - ST_* : 2-bit state encoding used by the loadable down-counter.
//   - NBITS_DEF : default count width.
//   - state_t : typed view of the same encoding for FSM code.
// No ports (package).
// -----------------------------------------------------------------------------
package contador_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int NBITS_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_HOLD = ST_HOLD,
        S_DONE = ST_DONE
    } state_t;

    // Countdown is "in progress" while running or paused.
    function automatic logic is_active(input state_t st);
        return (st == S_RUN) || (st == S_HOLD);
    endfunction

endpackage

// File: rtl/contador_regresivo.sv
// -----------------------------------------------------------------------------
// contador_regresivo
// Loadable down-counter / timer with pause and optional auto-reload.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   load        in   capture load_val into count and reload register, go idle
//   load_val    in   [nbits] value captured on load
//   start       in   begin countdown (IDLE) or restart from DONE
//   pause       in   level, freezes the countdown while high
//   auto_reload in   level, on reaching zero reload and keep running
//   count       out  [nbits] current count (registered)
//   busy        out  high while running or paused
//   done        out  registered one-cycle pulse on the edge count reaches 0
//   zero        out  combinational count == 0
// -----------------------------------------------------------------------------
module contador_regresivo
    import contador_pkg::*;
#(
    parameter int nbits = NBITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [nbits-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             auto_reload,
    output logic [nbits-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam logic [nbits-1:0] ONE = nbits'(1);

    state_t           r_state;
    logic [nbits-1:0] r_count;
    logic [nbits-1:0] r_reload;
    logic             r_done;

    state_t           w_state;
    logic [nbits-1:0] w_count;
    logic [nbits-1:0] w_reload;
    logic             w_done;

    // Next-state, next-count and done-pulse decision; priority load > start > pause > decrement.
    always_comb begin
        w_state  = r_state;
        w_count  = r_count;
        w_reload = r_reload;
        w_done   = 1'b0;
        if (load) begin
            w_count  = load_val;
            w_reload = load_val;
            w_state  = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Starting from zero would pulse nothing useful, so it is refused.
                    if (start && (r_count != '0)) begin
                        w_state = S_RUN;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        w_state = S_HOLD;
                    end else if (r_count > ONE) begin
                        w_count = r_count - ONE;
                    end else if (r_count == ONE) begin
                        w_done = 1'b1;
                        if (auto_reload) begin
                            w_count = r_reload;
                        end else begin
                            w_count = '0;
                            w_state = S_DONE;
                        end
                    end else begin
                        // Zero while running cannot be reached; park safely with no pulse.
                        w_state = S_DONE;
                    end
                end
                S_HOLD: begin
                    // Leaving HOLD costs one edge without decrementing.
                    if (!pause) begin
                        w_state = S_RUN;
                    end else begin
                        w_state = S_HOLD;
                    end
                end
                S_DONE: begin
                    if (start && (r_reload != '0)) begin
                        w_count = r_reload;
                        w_state = S_RUN;
                    end else begin
                        w_count = '0;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_count = '0;
                end
            endcase
        end
    end

    // State, count, reload value and done pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_count  <= w_count;
            r_reload <= w_reload;
            r_done   <= w_done;
        end
    end

    assign count = r_count;
    assign busy  = is_active(r_state);
    assign done  = r_done;
    assign zero  = (r_count == '0);

endmodule
